fhe_op_sequencer: RTL and testbench
===================================

Name: fhe_op_sequencer

Overview:
- Parametrised successor to the single-shot CPU controller. Queues FHE instructions in a small FIFO under a valid/ready handshake.
- Expands each instruction into a cycle-timed micro-op stream (ADD, TWIST, NTT, MUL, INTT, UNTWIST) with writeback, done and tag signalling.
- Sits between instruction issue and the regfile/functional-unit datapath. Control only; carries no polynomial data.

Parameters:
- REG_NPOLY, 16, number of regfile polynomials; IDX_W = $clog2(REG_NPOLY).
- FIFO_DEPTH, 4, instruction FIFO entries (power of 2, >=2).
- NTT_LAT, 4, cycles occupied by each NTT/INTT step (>=1).
- TAG_W, 4, instruction tag width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  FIFO can accept.
- instr_mode  in  3  0 NO_OP, 1 CT_CT_ADD, 2 CT_PT_ADD, 3 CT_PT_MUL, 4-7 illegal.
- instr_src0..instr_src3  in  IDX_W each  source indices.
- instr_dst0, instr_dst1  in  IDX_W each  destination indices.
- instr_tag  in  TAG_W  caller tag.
- fu_stall  in  1  datapath back-pressure.
- uop_valid  out  1  first cycle of a micro-op step.
- uop_kind  out  3  0 ADD, 1 TWIST, 2 NTT, 3 MUL, 4 INTT, 5 UNTWIST, 7 none.
- uop_half  out  1  0 = ciphertext A half, 1 = B half.
- uop_inverse  out  1  high during INTT.
- uop_src0..uop_src3  out  IDX_W each  current instruction sources.
- wb0_en, wb1_en  out  1 each  writeback strobes.
- wb_idx0, wb_idx1  out  IDX_W each  = current dst0/dst1.
- done  out  1  one-cycle completion pulse.
- done_tag  out  TAG_W  tag of completed instruction.
- err_illegal  out  1  pulse on illegal mode.
- busy  out  1  executing or FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.

Behaviour:
- Reset (reset=0, async): FIFO emptied; FSM to IDLE; step/cycle counters 0. All outputs 0 except uop_kind=7 and instr_ready=1. In-flight op discarded with no done.
- FIFO:
  - instr_ready = (fifo_count < FIFO_DEPTH), independent of a same-cycle pop.
  - Push on valid&ready. Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, EXEC.
  - IDLE with count>0: pop at the edge; load mode/indices/tag into current regs; go to EXEC with step=0, cyc=0.
  - Latency: instruction pushed at edge t is popped at t+1; its first uop_valid appears in the cycle after t+1.
- Step programs (each step lasts 1 cycle unless noted):
  - CT_CT_ADD: one ADD step, uop_half=0, wb0_en=wb1_en=1, done=1.
  - CT_PT_ADD: one ADD step, wb0_en=wb1_en=1, done=1 (datapath passes src0 through to dst0 and adds src1+src3 into dst1).
  - CT_PT_MUL: for h=0 then h=1: TWIST, NTT (NTT_LAT cycles), MUL, INTT (NTT_LAT cycles), UNTWIST.
    - UNTWIST of h asserts wb{h}_en. UNTWIST of h=1 also asserts done.
    - Total 2*(3+2*NTT_LAT) cycles.
  - NO_OP: one cycle with uop_valid=0, uop_kind=7, done=1.
  - Illegal: one cycle with done=1, err_illegal=1, no writeback.
- Step control:
  - uop_valid=1 only on cyc==0 of each step. uop_kind and uop_half hold for the whole step.
  - wb*/done assert on the final cycle of the final step.
  - After the last step: if count>0, pop the next instruction at that edge and remain in EXEC (back-to-back, zero bubbles); otherwise go to IDLE.
- fu_stall=1: step, cyc and FIFO pop frozen; uop_valid, wb*, done and err_illegal gated to 0; the frozen cycle re-presents its strobes after the stall drops. FIFO push is still allowed while stalled.
- done_tag is valid only while done=1; it is 0 otherwise.
- busy = (state==EXEC) | (count>0).

Test Plan:
- Reset then one CT_CT_ADD (src 1,2,3,4; dst 5,6; tag 3) pushed at edge 0 -> uop_valid/ADD, wb0_en=wb1_en=1, wb_idx 5/6, done=1 with done_tag=3, all in cycle 2; busy=0 in cycle 3.
- CT_PT_MUL with NTT_LAT=4 -> 22-cycle program; uop_valid pulses at offsets 0,1,5,6,10 for h=0 and 11,12,16,17,21 for h=1; uop_inverse high at offsets 6-9 and 17-20; wb0_en at offset 10; wb1_en and done at offset 21.
- Push 5 ADDs back-to-back with FIFO_DEPTH=4 while fu_stall=1 -> instr_ready falls after 4 accepts; release stall -> 5 done pulses on consecutive cycles, tags in push order.
- fu_stall held 3 cycles on the MUL step of h=0 -> uop_valid low for those 3 cycles, re-asserted once stall drops; total program length 25 cycles.
- Modes 0 and 6 queued -> done (tag preserved) for both; err_illegal only for mode 6; no wb strobes.
- reset driven low asynchronously at offset 8 of CT_PT_MUL -> all outputs clear immediately; no done; FIFO empty; fifo_count=0.

Source files
------------

// File: rtl/fhe_op_sequencer_if.sv
// fhe_op_sequencer_if
//   Connects instruction issue and the FHE datapath to fhe_op_sequencer.
//   The interface carries no polynomial data, only control.
//   Signal groups:
//     instr_*      : instruction offer. valid/ready handshake, with mode,
//                    four source indices, two destination indices and a tag.
//     fu_stall     : back-pressure from the functional units.
//     uop_*        : micro-op step strobe, kind, half, inverse flag and sources.
//     wb*_en/idx   : writeback strobes and destination indices.
//     done*, err_* : completion pulse with tag, and the illegal-mode pulse.
//     busy, fifo_count : occupancy status.
//   Modports:
//     master : the issuer/datapath side (the testbench).
//     slave  : the sequencer side.
interface fhe_op_sequencer_if #(
    parameter int REG_NPOLY  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
);
    localparam int IDX_W = $clog2(REG_NPOLY);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       instr_mode;
    logic [IDX_W-1:0] instr_src0;
    logic [IDX_W-1:0] instr_src1;
    logic [IDX_W-1:0] instr_src2;
    logic [IDX_W-1:0] instr_src3;
    logic [IDX_W-1:0] instr_dst0;
    logic [IDX_W-1:0] instr_dst1;
    logic [TAG_W-1:0] instr_tag;
    logic             fu_stall;
    logic             uop_valid;
    logic [2:0]       uop_kind;
    logic             uop_half;
    logic             uop_inverse;
    logic [IDX_W-1:0] uop_src0;
    logic [IDX_W-1:0] uop_src1;
    logic [IDX_W-1:0] uop_src2;
    logic [IDX_W-1:0] uop_src3;
    logic             wb0_en;
    logic             wb1_en;
    logic [IDX_W-1:0] wb_idx0;
    logic [IDX_W-1:0] wb_idx1;
    logic             done;
    logic [TAG_W-1:0] done_tag;
    logic             err_illegal;
    logic             busy;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output instr_valid, instr_mode, instr_src0, instr_src1, instr_src2, instr_src3,
               instr_dst0, instr_dst1, instr_tag, fu_stall,
        input  instr_ready, uop_valid, uop_kind, uop_half, uop_inverse,
               uop_src0, uop_src1, uop_src2, uop_src3,
               wb0_en, wb1_en, wb_idx0, wb_idx1, done, done_tag, err_illegal,
               busy, fifo_count
    );

    modport slave (
        input  instr_valid, instr_mode, instr_src0, instr_src1, instr_src2, instr_src3,
               instr_dst0, instr_dst1, instr_tag, fu_stall,
        output instr_ready, uop_valid, uop_kind, uop_half, uop_inverse,
               uop_src0, uop_src1, uop_src2, uop_src3,
               wb0_en, wb1_en, wb_idx0, wb_idx1, done, done_tag, err_illegal,
               busy, fifo_count
    );
endinterface

// File: rtl/fhe_op_sequencer.sv
// fhe_op_sequencer
//   Queues FHE instructions in a small FIFO and expands each one into a
//   cycle-timed micro-op stream for the regfile/functional-unit datapath.
//   The stream is made of ADD, TWIST, NTT, MUL, INTT and UNTWIST steps, with
//   writeback, done and tag signalling. The block is control only.
//   Ports:
//     clk   : rising-edge clock.
//     reset : asynchronous, active-low reset.
//     bus   : fhe_op_sequencer_if slave modport. It carries the instruction
//             handshake, stall, micro-op, writeback, completion and status
//             signals.
module fhe_op_sequencer #(
    parameter int REG_NPOLY  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int NTT_LAT    = 4,
    parameter int TAG_W      = 4
) (
    input logic               clk,
    input logic               reset,
    fhe_op_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(REG_NPOLY);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CYC_W = (NTT_LAT > 1) ? $clog2(NTT_LAT) : 1;

    localparam logic [CYC_W-1:0] NTT_LAST      = CYC_W'(NTT_LAT - 1);
    localparam logic [CNT_W-1:0] DEPTH_C       = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       MUL_LAST_STEP = 4'd9;
    localparam logic [3:0]       UNTWIST0_STEP = 4'd4;

    localparam logic [2:0] MODE_CC_ADD = 3'd1;
    localparam logic [2:0] MODE_CP_ADD = 3'd2;
    localparam logic [2:0] MODE_CP_MUL = 3'd3;
    localparam logic [2:0] KIND_ADD    = 3'd0;
    localparam logic [2:0] KIND_NONE   = 3'd7;
    localparam logic [2:0] SUB_NTT     = 3'd1;
    localparam logic [2:0] SUB_INTT    = 3'd3;

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;

    typedef struct packed {
        logic [2:0]       mode;
        logic [IDX_W-1:0] src0;
        logic [IDX_W-1:0] src1;
        logic [IDX_W-1:0] src2;
        logic [IDX_W-1:0] src3;
        logic [IDX_W-1:0] dst0;
        logic [IDX_W-1:0] dst1;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // CT_PT_MUL runs ten steps, five per ciphertext half. This function
    // gives the position within the half:
    // 0 TWIST, 1 NTT, 2 MUL, 3 INTT, 4 UNTWIST.
    function automatic logic [2:0] mul_sub(input logic [3:0] step);
        if (step >= 4'd5) begin
            return 3'(step - 4'd5);
        end
        return step[2:0];
    endfunction

    // NTT and INTT steps last NTT_LAT cycles. Every other step lasts one cycle.
    function automatic logic [CYC_W-1:0] mul_last_cyc(input logic [2:0] sub);
        return ((sub == SUB_NTT) || (sub == SUB_INTT)) ? NTT_LAST : '0;
    endfunction

    entry_t           fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_e           state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    entry_t           cur_q, cur_d;

    entry_t           in_entry;
    logic             ready, push, pop, exec, adv;
    logic             is_add, is_mul, is_ill;
    logic [2:0]       sub;
    logic [CYC_W-1:0] last_cyc;
    logic             step_end, prog_end;
    logic [2:0]       kind;

    assign in_entry = '{mode: bus.instr_mode, src0: bus.instr_src0, src1: bus.instr_src1,
                        src2: bus.instr_src2, src3: bus.instr_src3, dst0: bus.instr_dst0,
                        dst1: bus.instr_dst1, tag: bus.instr_tag};

    // Readiness depends only on the registered count. A pop in the same
    // cycle does not make room early.
    assign ready = (count_q < DEPTH_C);

    always_comb begin
        is_add   = (cur_q.mode == MODE_CC_ADD) || (cur_q.mode == MODE_CP_ADD);
        is_mul   = (cur_q.mode == MODE_CP_MUL);
        is_ill   = cur_q.mode[2];
        sub      = mul_sub(step_q);
        last_cyc = is_mul ? mul_last_cyc(sub) : '0;
        step_end = (cyc_q == last_cyc);
        prog_end = step_end && (is_mul ? (step_q == MUL_LAST_STEP) : 1'b1);
        exec     = (state_q == EXEC);
        adv      = exec && !bus.fu_stall;
        push     = bus.instr_valid && ready;
        // Pop when idle, or on the final cycle of the program. The final
        // cycle case gives back-to-back execution with no bubble. A stall
        // freezes the pop in both cases.
        pop      = !bus.fu_stall && (count_q != '0) && (!exec || prog_end);

        kind = KIND_NONE;
        if (exec && is_add) begin
            kind = KIND_ADD;
        end else if (exec && is_mul) begin
            kind = 3'(sub + 3'd1);
        end

        state_d  = state_q;
        step_d   = step_q;
        cyc_d    = cyc_q;
        cur_d    = cur_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (pop) begin
            state_d = EXEC;
            step_d  = '0;
            cyc_d   = '0;
            cur_d   = fifo_q[rd_ptr_q];
        end else if (adv) begin
            if (prog_end) begin
                state_d = IDLE;
                step_d  = '0;
                cyc_d   = '0;
            end else if (step_end) begin
                step_d = step_q + 4'd1;
                cyc_d  = '0;
            end else begin
                cyc_d = cyc_q + CYC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            cyc_q    <= '0;
            cur_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cyc_q    <= cyc_d;
            cur_q    <= cur_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage holds only data. Validity is tracked by the pointers and
    // the count, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= in_entry;
        end
    end

    // Strobes are gated by the stall. kind, half and inverse stay steady for
    // the whole step, including stalled cycles.
    assign bus.instr_ready = ready;
    assign bus.uop_valid   = adv && (cyc_q == '0) && (is_add || is_mul);
    assign bus.uop_kind    = kind;
    assign bus.uop_half    = exec && is_mul && (step_q >= 4'd5);
    assign bus.uop_inverse = exec && is_mul && (sub == SUB_INTT);
    assign bus.uop_src0    = cur_q.src0;
    assign bus.uop_src1    = cur_q.src1;
    assign bus.uop_src2    = cur_q.src2;
    assign bus.uop_src3    = cur_q.src3;
    assign bus.wb0_en      = adv && ((is_add && prog_end) ||
                                     (is_mul && (step_q == UNTWIST0_STEP) && step_end));
    assign bus.wb1_en      = adv && (is_add || is_mul) && prog_end;
    assign bus.wb_idx0     = cur_q.dst0;
    assign bus.wb_idx1     = cur_q.dst1;
    assign bus.done        = adv && prog_end;
    assign bus.done_tag    = (adv && prog_end) ? cur_q.tag : '0;
    assign bus.err_illegal = adv && is_ill;
    assign bus.busy        = exec || (count_q != '0);
    assign bus.fifo_count  = count_q;
endmodule

// File: tb/tb_fhe_op_sequencer.sv
module tb_fhe_op_sequencer;
    localparam int REG_NPOLY  = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int NTT_LAT    = 4;
    localparam int TAG_W      = 4;
    localparam int IDX_W      = $clog2(REG_NPOLY);
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [2:0]       mode;
        logic [IDX_W-1:0] s0, s1, s2, s3, d0, d1;
        logic [TAG_W-1:0] tag;
    } ins_t;

    typedef struct packed {
        logic v; logic [2:0] kind; logic half, inv, wb0, wb1, done, err;
    } rec_t;

    typedef struct packed {
        logic v; logic [2:0] kind; logic half, inv, wb0, wb1, done;
        logic [TAG_W-1:0] tag; logic err, busy, rdy; logic [CNT_W-1:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_checks = 0;
    int n_errors = 0;

    ins_t mq[$];
    rec_t mt[$];
    ins_t mcur;

    fhe_op_sequencer_if #(.REG_NPOLY(REG_NPOLY), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) bus ();

    fhe_op_sequencer #(.REG_NPOLY(REG_NPOLY), .FIFO_DEPTH(FIFO_DEPTH),
                       .NTT_LAT(NTT_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input ins_t i);
        bus.instr_valid = v;
        bus.instr_mode  = i.mode;
        bus.instr_src0  = i.s0;
        bus.instr_src1  = i.s1;
        bus.instr_src2  = i.s2;
        bus.instr_src3  = i.s3;
        bus.instr_dst0  = i.d0;
        bus.instr_dst1  = i.d1;
        bus.instr_tag   = i.tag;
    endtask

    function automatic ins_t rand_ins();
        ins_t i;
        i.mode = ($urandom_range(0, 3) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
        i.s0 = IDX_W'($urandom_range(0, REG_NPOLY - 1));
        i.s1 = IDX_W'($urandom_range(0, REG_NPOLY - 1));
        i.s2 = IDX_W'($urandom_range(0, REG_NPOLY - 1));
        i.s3 = IDX_W'($urandom_range(0, REG_NPOLY - 1));
        i.d0 = IDX_W'($urandom_range(0, REG_NPOLY - 1));
        i.d1 = IDX_W'($urandom_range(0, REG_NPOLY - 1));
        i.tag = TAG_W'($urandom);
        return i;
    endfunction

    function automatic obs_t obs();
        obs_t o;
        o.v = bus.uop_valid; o.kind = bus.uop_kind; o.half = bus.uop_half;
        o.inv = bus.uop_inverse; o.wb0 = bus.wb0_en; o.wb1 = bus.wb1_en;
        o.done = bus.done; o.tag = bus.done_tag; o.err = bus.err_illegal;
        o.busy = bus.busy; o.rdy = bus.instr_ready; o.cnt = bus.fifo_count;
        return o;
    endfunction

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.kind = 3'd7;
        o.rdy  = 1'b1;
        return o;
    endfunction

    // Reference timeline of one CT_PT_MUL half at NTT_LAT=4, taken from the
    // listed offsets: TWIST 0, NTT 1-4, MUL 5, INTT 6-9, UNTWIST 10.
    function automatic logic [2:0] plan_kind(input int o);
        if (o == 0) return 3'd1;
        if (o <= 4) return 3'd2;
        if (o == 5) return 3'd3;
        if (o <= 9) return 3'd4;
        return 3'd5;
    endfunction

    function automatic logic plan_valid(input int o);
        return (o == 0) || (o == 1) || (o == 5) || (o == 6) || (o == 10);
    endfunction

    // Behavioural model: each instruction becomes a list of per-cycle records.
    task automatic add_step(input logic [2:0] k, input logic h, input int len, input logic vv,
                            input logic w0, input logic w1, input logic d, input logic e);
        for (int i = 0; i < len; i++) begin
            rec_t r;
            r.v = vv && (i == 0); r.kind = k; r.half = h; r.inv = (k == 3'd4);
            r.wb0 = w0 && (i == len - 1); r.wb1 = w1 && (i == len - 1);
            r.done = d && (i == len - 1); r.err = e && (i == len - 1);
            mt.push_back(r);
        end
    endtask

    task automatic build_trace(input logic [2:0] mode);
        case (mode)
            3'd0: add_step(3'd7, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            3'd1, 3'd2: add_step(3'd0, 1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            3'd3: begin
                for (int h = 0; h < 2; h++) begin
                    add_step(3'd1, h == 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    add_step(3'd2, h == 1, NTT_LAT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    add_step(3'd3, h == 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    add_step(3'd4, h == 1, NTT_LAT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    add_step(3'd5, h == 1, 1, 1'b1, h == 0, h == 1, h == 1, 1'b0);
                end
            end
            default: add_step(3'd7, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        endcase
    endtask

    task automatic test_reset();
        obs_t e;
        drive(1'b0, '0);
        bus.fu_stall = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        e = idle_obs();
        n_checks++;
        if (obs() !== e) begin
            n_errors++;
            $display("FAIL reset_hold: got %h expected %h", obs(), e);
        end
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs() !== e) begin
            n_errors++;
            $display("FAIL reset_release: got %h expected %h", obs(), e);
        end
        cyc();
    endtask

    task automatic test_single_add();
        ins_t i;
        obs_t e;
        i.mode = 3'd1; i.s0 = 1; i.s1 = 2; i.s2 = 3; i.s3 = 4; i.d0 = 5; i.d1 = 6; i.tag = 3;
        drive(1'b1, i);
        cyc();
        drive(1'b0, i);
        @(negedge clk);
        e = idle_obs(); e.busy = 1'b1; e.cnt = 1;
        n_checks++;
        if (obs() !== e) begin
            n_errors++;
            $display("FAIL add_queued: got %h expected %h", obs(), e);
        end
        cyc();
        @(negedge clk);
        e = '0; e.v = 1; e.kind = 3'd0; e.wb0 = 1; e.wb1 = 1; e.done = 1; e.tag = 3;
        e.busy = 1; e.rdy = 1; e.cnt = 0;
        n_checks++;
        if (obs() !== e) begin
            n_errors++;
            $display("FAIL add_exec: got %h expected %h", obs(), e);
        end
        n_checks++;
        if ({bus.uop_src0, bus.uop_src1, bus.uop_src2, bus.uop_src3, bus.wb_idx0, bus.wb_idx1}
            !== {i.s0, i.s1, i.s2, i.s3, i.d0, i.d1}) begin
            n_errors++;
            $display("FAIL add_indices: got %h expected %h",
                     {bus.uop_src0, bus.uop_src1, bus.uop_src2, bus.uop_src3, bus.wb_idx0, bus.wb_idx1},
                     {i.s0, i.s1, i.s2, i.s3, i.d0, i.d1});
        end
        cyc();
        @(negedge clk);
        e = idle_obs();
        n_checks++;
        if (obs() !== e) begin
            n_errors++;
            $display("FAIL add_after: got %h expected %h", obs(), e);
        end
        cyc();
    endtask

    task automatic test_mul_program();
        ins_t i;
        obs_t e;
        int o;
        i = rand_ins(); i.mode = 3'd3; i.tag = 7;
        drive(1'b1, i);
        cyc();
        drive(1'b0, i);
        cyc();
        for (int off = 0; off < 22; off++) begin
            @(negedge clk);
            o = off % 11;
            e = '0;
            e.v = plan_valid(o); e.kind = plan_kind(o); e.half = (off >= 11);
            e.inv = (o >= 6) && (o <= 9); e.wb0 = (off == 10); e.wb1 = (off == 21);
            e.done = (off == 21); e.tag = (off == 21) ? 4'd7 : 4'd0;
            e.busy = 1; e.rdy = 1; e.cnt = 0;
            n_checks++;
            if (obs() !== e) begin
                n_errors++;
                $display("FAIL mul_offset_%0d: got %h expected %h", off, obs(), e);
            end
            cyc();
        end
        @(negedge clk);
        n_checks++;
        if (obs() !== idle_obs()) begin
            n_errors++;
            $display("FAIL mul_after: got %h expected %h", obs(), idle_obs());
        end
        cyc();
    endtask

    task automatic test_mul_stall();
        ins_t i;
        int p, o;
        logic st;
        logic [5:0] got, exp;
        i = rand_ins(); i.mode = 3'd3; i.tag = 2;
        drive(1'b1, i);
        cyc();
        drive(1'b0, i);
        cyc();
        for (int c = 0; c < 25; c++) begin
            st = (c >= 5) && (c < 8);
            bus.fu_stall = st;
            @(negedge clk);
            p = (c < 5) ? c : ((c < 8) ? 5 : c - 3);
            o = p % 11;
            exp = {plan_valid(o) && !st, plan_kind(o), (p == 10) && !st, (p == 21)};
            got = {bus.uop_valid, bus.uop_kind, bus.wb0_en, bus.done};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL stall_cycle_%0d: got %h expected %h", c, got, exp);
            end
            cyc();
        end
        bus.fu_stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_errors++;
            $display("FAIL stall_length: got busy/done %b expected 00", {bus.busy, bus.done});
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        ins_t i;
        int acc;
        logic [CNT_W+1:0] got, exp;
        logic [TAG_W+1:0] got2, exp2;
        i.mode = 3'd1; i.s0 = 0; i.s1 = 1; i.s2 = 2; i.s3 = 3; i.d0 = 4; i.d1 = 5;
        acc = 0;
        bus.fu_stall = 1'b1;
        for (int c = 0; c < 6; c++) begin
            i.tag = TAG_W'(acc + 1);
            drive(1'b1, i);
            @(negedge clk);
            exp = {(c < 4), 1'b0, CNT_W'((c < 4) ? c : 4)};
            got = {bus.instr_ready, bus.done, bus.fifo_count};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL b2b_fill_%0d: got %h expected %h", c, got, exp);
            end
            if (bus.instr_ready) acc++;
            cyc();
        end
        bus.fu_stall = 1'b0;
        for (int r = 0; r < 7; r++) begin
            i.tag = TAG_W'(acc + 1);
            drive(acc < 5, i);
            @(negedge clk);
            exp2 = {(r <= 5), (r >= 1) && (r <= 5), TAG_W'((r >= 1 && r <= 5) ? r : 0)};
            got2 = {bus.busy, bus.done, bus.done_tag};
            n_checks++;
            if (got2 !== exp2) begin
                n_errors++;
                $display("FAIL b2b_drain_%0d: got %h expected %h", r, got2, exp2);
            end
            if (bus.instr_valid && bus.instr_ready) acc++;
            cyc();
        end
        drive(1'b0, i);
    endtask

    task automatic test_nop_illegal();
        ins_t i;
        obs_t e;
        i = rand_ins(); i.mode = 3'd0; i.tag = 9;
        drive(1'b1, i);
        cyc();
        i.mode = 3'd6; i.tag = 10;
        drive(1'b1, i);
        cyc();
        drive(1'b0, i);
        @(negedge clk);
        e = idle_obs(); e.done = 1; e.tag = 9; e.busy = 1; e.cnt = 1;
        n_checks++;
        if (obs() !== e) begin
            n_errors++;
            $display("FAIL nop_exec: got %h expected %h", obs(), e);
        end
        cyc();
        @(negedge clk);
        e = idle_obs(); e.done = 1; e.tag = 10; e.err = 1; e.busy = 1; e.cnt = 0;
        n_checks++;
        if (obs() !== e) begin
            n_errors++;
            $display("FAIL illegal_exec: got %h expected %h", obs(), e);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (obs() !== idle_obs()) begin
            n_errors++;
            $display("FAIL illegal_after: got %h expected %h", obs(), idle_obs());
        end
        cyc();
    endtask

    task automatic test_async_reset();
        ins_t i;
        i = rand_ins(); i.mode = 3'd3; i.tag = 5;
        drive(1'b1, i);
        cyc();
        i.mode = 3'd1; i.tag = 6;
        drive(1'b1, i);
        cyc();
        drive(1'b0, i);
        for (int k = 0; k < 8; k++) cyc();
        n_checks++;
        if ({bus.uop_inverse, bus.busy, bus.fifo_count} !== {2'b11, CNT_W'(1)}) begin
            n_errors++;
            $display("FAIL areset_pre: got %h expected %h",
                     {bus.uop_inverse, bus.busy, bus.fifo_count}, {2'b11, CNT_W'(1)});
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== idle_obs()) begin
            n_errors++;
            $display("FAIL areset_immediate: got %h expected %h", obs(), idle_obs());
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== idle_obs()) begin
                n_errors++;
                $display("FAIL areset_hold_%0d: got %h expected %h", k, obs(), idle_obs());
            end
        end
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== idle_obs()) begin
                n_errors++;
                $display("FAIL areset_after_%0d: got %h expected %h", k, obs(), idle_obs());
            end
            cyc();
        end
    endtask

    task automatic test_random();
        ins_t inc;
        logic st, vld, psh;
        obs_t e, g;
        rec_t r;
        logic [6*IDX_W-1:0] gi, ei;
        rst_n = 1'b0;
        bus.fu_stall = 1'b0;
        drive(1'b0, '0);
        mq.delete(); mt.delete(); mcur = '0;
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            st  = ($urandom_range(0, 9) == 0);
            vld = ($urandom_range(0, 3) == 0);
            inc = rand_ins();
            bus.fu_stall = st;
            drive(vld, inc);
            @(negedge clk);
            r = '0; r.kind = 3'd7;
            if (mt.size() > 0) r = mt[0];
            e.v = r.v && !st; e.kind = r.kind; e.half = r.half; e.inv = r.inv;
            e.wb0 = r.wb0 && !st; e.wb1 = r.wb1 && !st; e.done = r.done && !st;
            e.tag = e.done ? mcur.tag : '0; e.err = r.err && !st;
            e.busy = (mt.size() > 0) || (mq.size() > 0);
            e.rdy = (mq.size() < FIFO_DEPTH); e.cnt = CNT_W'(mq.size());
            g = obs();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL rand_obs cycle %0d: got %h expected %h", c, g, e);
            end
            gi = {bus.uop_src0, bus.uop_src1, bus.uop_src2, bus.uop_src3, bus.wb_idx0, bus.wb_idx1};
            ei = {mcur.s0, mcur.s1, mcur.s2, mcur.s3, mcur.d0, mcur.d1};
            n_checks++;
            if (gi !== ei) begin
                n_errors++;
                $display("FAIL rand_idx cycle %0d: got %h expected %h", c, gi, ei);
            end
            @(posedge clk);
            psh = vld && (mq.size() < FIFO_DEPTH);
            if (!st && mt.size() > 0) void'(mt.pop_front());
            if (!st && mt.size() == 0 && mq.size() > 0) begin
                mcur = mq.pop_front();
                build_trace(mcur.mode);
            end
            if (psh) mq.push_back(inc);
            #1;
        end
        bus.fu_stall = 1'b0;
        drive(1'b0, inc);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_mul_program();
        test_mul_stall();
        test_back_to_back();
        test_nop_illegal();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
